ddr3_frame_reader: RTL and testbench
====================================

Name: ddr3_frame_reader

Overview:
- Consumer end of the ping-pong DDR3 frame-buffer handshake, in the DDR3 clock domain.
- Watches the per-buffer full flags and reads the full buffer as Avalon-MM read bursts.
- Streams the words into the downstream pixel FIFO.
- Pulses the matching clear strobe when the frame has been fully received.

Parameters:
- ADDR_W, 26, Avalon word-address width; same width as the buffer offsets.
- DATA_W, 64, read data width.
- BURST_LEN, 8, words per read burst; power of two, at least 2.
- FRAME_WORDS, 76800, words per frame; must be a multiple of BURST_LEN.
- SPACE_W, 10, width of the FIFO free-space count.

Ports:
- clk  in  1  DDR3 user clock
- reset_n  in  1  async active-low reset
- rd_enable  in  1  level; allows new frames to start
- buffer0_full  in  1  level; buffer 0 holds a complete frame
- buffer1_full  in  1  level; buffer 1 holds a complete frame
- buffer0_offset  in  ADDR_W  word base address of buffer 0
- buffer1_offset  in  ADDR_W  word base address of buffer 1
- clear_buffer0  out  1  one-cycle pulse; buffer 0 consumed
- clear_buffer1  out  1  one-cycle pulse; buffer 1 consumed
- avm_address  out  ADDR_W  burst start word address
- avm_read  out  1  read request
- avm_burstcount  out  log2(BURST_LEN)+1  constant BURST_LEN
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data strobe; cannot be back-pressured
- fifo_space  in  SPACE_W  free entries in the pixel FIFO
- pix_data  out  DATA_W  word to FIFO
- pix_valid  out  1  write strobe to FIFO
- pix_sof  out  1  high with the first word of each frame
- busy  out  1  high from frame start until its clear pulse

Behaviour:
- Reset is asynchronous on reset_n, active-low; the block is clocked on clk.
- Reset values: all outputs 0. cur_buf=0, all counters 0, state IDLE.
- A reset mid-frame abandons the frame. No clear pulse is issued for it.
- States are IDLE, ISSUE, DRAIN, CLEAR.
- IDLE: when rd_enable=1 and the full flag of cur_buf is 1:
  - latch that buffer's offset into base;
  - zero issued_cnt and rcv_cnt;
  - set busy=1 and go to ISSUE.
- ISSUE: assert avm_read with avm_address=base+issued_cnt (modulo 2^ADDR_W) and avm_burstcount=BURST_LEN.
  - Assert only when fifo_space >= inflight+BURST_LEN, where inflight = issued_cnt − rcv_cnt.
  - avm_read, avm_address and avm_burstcount are held stable while avm_waitrequest=1.
  - On avm_read & ~avm_waitrequest: issued_cnt += BURST_LEN.
  - When issued_cnt reaches FRAME_WORDS, deassert avm_read and go to DRAIN.
- Both ISSUE and DRAIN accept data every cycle:
  - each avm_readdatavalid registers pix_data=avm_readdata and pix_valid=1, giving 1-cycle latency;
  - rcv_cnt increments on each avm_readdatavalid;
  - pix_sof=1 on the word with rcv_cnt==0.
- DRAIN: when the last word arrives (rcv_cnt becomes FRAME_WORDS), go to CLEAR.
- CLEAR: for one cycle, pulse clear_buffer[cur_buf]. Then toggle cur_buf, set busy=0 and go to IDLE.
  - A full flag needs ≥1 cycle to fall after a clear. It is safe to ignore because the next frame samples the other buffer.
- rd_enable affects only the IDLE→ISSUE decision. Deasserting it mid-frame completes the frame, including its clear.
- Both full flags high in IDLE: only cur_buf is considered, so strict alternation 0,1,0,1… is kept.
- Data-accept edge case: avm_readdatavalid in the same cycle as a read acceptance is handled, and both counters update.
- Counter widths: issued_cnt and rcv_cnt are wide enough to hold FRAME_WORDS. Address addition wraps silently.

Optional Feature:
- Macro: DDR3_RD_FRAME_REPEAT_EN.
- Defined: in IDLE with rd_enable=1, cur_buf not full and at least one frame completed since reset, the block re-reads the last completed buffer at its stored base.
  - No clear pulse is issued for a repeat frame.
  - cur_buf is not toggled.
  - pix_sof is still asserted.
  - This keeps the display fed. Tearing is tolerated if the writer refills that buffer.
- Undefined: IDLE waits for the cur_buf full flag.

Decomposition:
- Shared package ddr3_ctrl_pkg holds:
  - state enum (IDLE/ISSUE/DRAIN/CLEAR);
  - BURSTCOUNT_W = $clog2(BURST_LEN)+1;
  - FRAME_CNT_W = $clog2(FRAME_WORDS+1).
- One natural sub-module, ddr3_rd_credit. It holds the issued/received counters and the space check, and outputs can_issue and frame_rcv_done.

Test Plan (BURST_LEN=8, FRAME_WORDS=32 on the bench):
- Basic frame:
  - stimulus: buffer0_full=1, offset 0x100, fifo_space=64, no waitrequest;
  - response: 4 bursts at 0x100/0x108/0x110/0x118, 32 pix_valid with pix_sof on the first, one clear_buffer0 pulse one cycle after the last data, then busy=0.
- Ping-pong:
  - stimulus: both full, offsets 0x000/0x400;
  - response: frame from 0x000 then clear_buffer0, frame from 0x400 then clear_buffer1, strictly alternating.
- Back-pressure:
  - stimulus: fifo_space=10; random waitrequest;
  - response: never more than one burst in flight, address and read held stable during waitrequest, all 32 words in order.
- Wrap:
  - stimulus: offset 0x3FFFFF8 with ADDR_W=26;
  - response: second burst address 0x0000000.
- Reset mid-frame:
  - stimulus: reset_n low after the 2nd burst;
  - response: all outputs 0 immediately, no clear pulse; the next frame restarts at buffer 0.
- Repeat (macro on):
  - stimulus: after buffer 0 is consumed, buffer1_full stays 0;
  - response: buffer 0 re-read with pix_sof and no clear pulse.
  - Macro off: block idles.

Source files
------------

// File: rtl/ddr3_ctrl_pkg.sv
// Shared types and width helpers for the DDR3 frame-buffer controller blocks.
package ddr3_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CLEAR
    } rd_state_t;

    // BURSTCOUNT_W for a given burst length
    function automatic int burstcount_w(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

    // FRAME_CNT_W: wide enough to hold FRAME_WORDS itself
    function automatic int frame_cnt_w(input int frame_words);
        return $clog2(frame_words + 1);
    endfunction

endpackage

// File: rtl/ddr3_rd_credit.sv
// Issued/received word counters for one frame and the FIFO free-space credit check.
module ddr3_rd_credit
    import ddr3_ctrl_pkg::*;
#(
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 76800,
    parameter int SPACE_W     = 10,
    parameter int CNT_W       = frame_cnt_w(FRAME_WORDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               issue_accept,
    input  logic               data_accept,
    input  logic [SPACE_W-1:0] fifo_space,
    output logic [CNT_W-1:0]   issued_cnt,
    output logic               can_issue,
    output logic               issue_done,
    output logic               rcv_first,
    output logic               frame_rcv_done
);

    localparam int CMP_W = ((CNT_W > SPACE_W) ? CNT_W : SPACE_W) + 1;

    logic [CNT_W-1:0] issued_cnt_reg;
    logic [CNT_W-1:0] rcv_cnt_reg;
    logic [CNT_W-1:0] inflight;
    logic [CMP_W-1:0] space_need;
    logic [CMP_W-1:0] space_have;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_cnt_reg <= '0;
            rcv_cnt_reg    <= '0;
        end else if (start) begin
            issued_cnt_reg <= '0;
            rcv_cnt_reg    <= '0;
        end else begin
            if (issue_accept)
                issued_cnt_reg <= issued_cnt_reg + CNT_W'(BURST_LEN);
            if (data_accept)
                rcv_cnt_reg <= rcv_cnt_reg + CNT_W'(1);
        end
    end

    // Every word already requested but not yet returned still needs a FIFO slot.
    assign inflight   = issued_cnt_reg - rcv_cnt_reg;
    assign space_need = CMP_W'(inflight) + CMP_W'(BURST_LEN);
    assign space_have = CMP_W'(fifo_space);

    assign issued_cnt     = issued_cnt_reg;
    assign issue_done     = (issued_cnt_reg == CNT_W'(FRAME_WORDS));
    assign can_issue      = !issue_done && (space_have >= space_need);
    assign rcv_first      = (rcv_cnt_reg == '0);
    assign frame_rcv_done = data_accept && (rcv_cnt_reg == CNT_W'(FRAME_WORDS - 1));

endmodule

// File: rtl/ddr3_frame_reader.sv
// Consumer side of the ping-pong DDR3 frame buffer: bursts a full buffer into the pixel FIFO.
// Optional DDR3_RD_FRAME_REPEAT_EN re-reads the last completed buffer while the next is not full.
module ddr3_frame_reader
    import ddr3_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 64,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 76800,
    parameter int SPACE_W     = 10
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                rd_enable,
    input  logic                                buffer0_full,
    input  logic                                buffer1_full,
    input  logic [ADDR_W-1:0]                   buffer0_offset,
    input  logic [ADDR_W-1:0]                   buffer1_offset,
    output logic                                clear_buffer0,
    output logic                                clear_buffer1,
    output logic [ADDR_W-1:0]                   avm_address,
    output logic                                avm_read,
    output logic [burstcount_w(BURST_LEN)-1:0]  avm_burstcount,
    input  logic                                avm_waitrequest,
    input  logic [DATA_W-1:0]                   avm_readdata,
    input  logic                                avm_readdatavalid,
    input  logic [SPACE_W-1:0]                  fifo_space,
    output logic [DATA_W-1:0]                   pix_data,
    output logic                                pix_valid,
    output logic                                pix_sof,
    output logic                                busy
);

    localparam int CNT_W        = frame_cnt_w(FRAME_WORDS);
    localparam int BURSTCOUNT_W = burstcount_w(BURST_LEN);

    rd_state_t         state_reg, state_next;
    logic              cur_buf_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              avm_read_reg;
    logic [ADDR_W-1:0] avm_address_reg;
    logic [DATA_W-1:0] pix_data_reg;
    logic              pix_valid_reg;
    logic              pix_sof_reg;

    logic              cur_full;
    logic              start_frame;
    logic              start;
    logic              repeat_frame;
    logic              issue_accept;
    logic              data_accept;
    logic [CNT_W-1:0]  issued_cnt;
    logic              can_issue;
    logic              issue_done;
    logic              rcv_first;
    logic              frame_rcv_done;

`ifdef DDR3_RD_FRAME_REPEAT_EN
    logic              start_repeat;
    logic              repeat_reg;
    logic              have_frame_reg;
    logic [ADDR_W-1:0] last_base_reg;

    assign start        = start_frame | start_repeat;
    assign repeat_frame = repeat_reg;
`else
    assign start        = start_frame;
    assign repeat_frame = 1'b0;
`endif

    assign cur_full     = cur_buf_reg ? buffer1_full : buffer0_full;
    assign issue_accept = avm_read_reg && !avm_waitrequest;
    assign data_accept  = avm_readdatavalid && ((state_reg == ISSUE) || (state_reg == DRAIN));

    ddr3_rd_credit #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .SPACE_W     (SPACE_W),
        .CNT_W       (CNT_W)
    ) u_credit (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .issue_accept   (issue_accept),
        .data_accept    (data_accept),
        .fifo_space     (fifo_space),
        .issued_cnt     (issued_cnt),
        .can_issue      (can_issue),
        .issue_done     (issue_done),
        .rcv_first      (rcv_first),
        .frame_rcv_done (frame_rcv_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
`ifdef DDR3_RD_FRAME_REPEAT_EN
        start_repeat = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (rd_enable && cur_full) begin
                    start_frame = 1'b1;
                    state_next  = ISSUE;
                end
`ifdef DDR3_RD_FRAME_REPEAT_EN
                else if (rd_enable && have_frame_reg) begin
                    start_repeat = 1'b1;
                    state_next   = ISSUE;
                end
`endif
            end
            ISSUE: begin
                // issue_done rises on the acceptance edge, which also drops avm_read
                if (issue_done)
                    state_next = frame_rcv_done ? CLEAR : DRAIN;
            end
            DRAIN: begin
                if (frame_rcv_done)
                    state_next = CLEAR;
            end
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_buf_reg     <= 1'b0;
            base_reg        <= '0;
            avm_read_reg    <= 1'b0;
            avm_address_reg <= '0;
            pix_data_reg    <= '0;
            pix_valid_reg   <= 1'b0;
            pix_sof_reg     <= 1'b0;
        end else begin
            pix_valid_reg <= data_accept;
            pix_sof_reg   <= data_accept && rcv_first;
            if (data_accept)
                pix_data_reg <= avm_readdata;

            if (start_frame)
                base_reg <= cur_buf_reg ? buffer1_offset : buffer0_offset;
`ifdef DDR3_RD_FRAME_REPEAT_EN
            if (start_repeat)
                base_reg <= last_base_reg;
`endif

            // A request stays frozen until accepted; the next one is only
            // evaluated after the counters reflect the accepted burst.
            if (state_reg == ISSUE) begin
                if (avm_read_reg) begin
                    if (!avm_waitrequest)
                        avm_read_reg <= 1'b0;
                end else if (can_issue) begin
                    avm_read_reg    <= 1'b1;
                    avm_address_reg <= base_reg + ADDR_W'(issued_cnt);
                end
            end

            if ((state_reg == CLEAR) && !repeat_frame)
                cur_buf_reg <= ~cur_buf_reg;
        end
    end

`ifdef DDR3_RD_FRAME_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            repeat_reg     <= 1'b0;
            have_frame_reg <= 1'b0;
            last_base_reg  <= '0;
        end else begin
            if (start)
                repeat_reg <= start_repeat;
            if ((state_reg == CLEAR) && !repeat_reg) begin
                have_frame_reg <= 1'b1;
                last_base_reg  <= base_reg;
            end
        end
    end
`endif

    assign clear_buffer0  = (state_reg == CLEAR) && !repeat_frame && !cur_buf_reg;
    assign clear_buffer1  = (state_reg == CLEAR) && !repeat_frame && cur_buf_reg;
    assign busy           = (state_reg != IDLE);
    assign avm_read       = avm_read_reg;
    assign avm_address    = avm_address_reg;
    assign avm_burstcount = avm_read_reg ? BURSTCOUNT_W'(BURST_LEN) : '0;
    assign pix_data       = pix_data_reg;
    assign pix_valid      = pix_valid_reg;
    assign pix_sof        = pix_sof_reg;

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Self-checking bench for ddr3_frame_reader: randomised Avalon slave plus a frame-level reference model.
module tb_ddr3_frame_reader;

    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 64;
    localparam int BURST_LEN   = 8;
    localparam int FRAME_WORDS = 32;
    localparam int SPACE_W     = 10;
    localparam int NBURST      = FRAME_WORDS / BURST_LEN;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rd_enable;
    logic              buffer0_full;
    logic              buffer1_full;
    logic [ADDR_W-1:0] buffer0_offset;
    logic [ADDR_W-1:0] buffer1_offset;
    logic              clear_buffer0;
    logic              clear_buffer1;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [SPACE_W-1:0] fifo_space;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_sof;
    logic              busy;

    always #5 clk = ~clk;

    ddr3_frame_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .SPACE_W     (SPACE_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rd_enable         (rd_enable),
        .buffer0_full      (buffer0_full),
        .buffer1_full      (buffer1_full),
        .buffer0_offset    (buffer0_offset),
        .buffer1_offset    (buffer1_offset),
        .clear_buffer0     (clear_buffer0),
        .clear_buffer1     (clear_buffer1),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .fifo_space        (fifo_space),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_sof           (pix_sof),
        .busy              (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base, input int off);
        logic [ADDR_W-1:0] r;
        r = base + ADDR_W'(off);
        return r;
    endfunction

    // Memory contents: every word is a fixed function of its address.
    function automatic logic [63:0] word_of(input logic [ADDR_W-1:0] a);
        return {6'd0, a ^ 26'h2ABCDEF, 6'd0, a};
    endfunction

    // Reference-model state for the frame currently expected
    logic [ADDR_W-1:0] exp_base = '0;
    int rx_idx    = 0;
    int burst_idx = 0;

    // Avalon slave / monitor state
    logic [ADDR_W-1:0] bq[$];
    logic [ADDR_W-1:0] held_addr = '0;
    bit req_pending = 1'b0;
    bit rand_wait   = 1'b0;
    bit rand_gap    = 1'b0;
    int widx = 0;
    int acc_total = 0;
    int dlv_total = 0;
    int cyc = 0;
    int last_drive_cyc = 0;
    int clear_cyc = 0;
    int clr0_cnt = 0;
    int clr1_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            bq.delete();
            widx = 0;
            dlv_total = acc_total;
            req_pending = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
        end else begin
            if (pix_valid) begin
                chk("pix_data", pix_data, word_of(addr_at(exp_base, rx_idx)));
                chk("pix_sof", pix_sof, rx_idx == 0);
                rx_idx++;
            end
            if (clear_buffer0) clr0_cnt++;
            if (clear_buffer1) clr1_cnt++;
            if (clear_buffer0 || clear_buffer1) clear_cyc = cyc;

            if (req_pending) begin
                chk("hold_read", avm_read, 1);
                chk("hold_addr", avm_address, held_addr);
                chk("hold_burstcount", avm_burstcount, BURST_LEN);
            end else if (avm_read) begin
                chk("burst_addr", avm_address, addr_at(exp_base, burst_idx * BURST_LEN));
                chk("burstcount", avm_burstcount, BURST_LEN);
                chk("burst_in_frame", burst_idx < NBURST, 1);
                chk("fifo_credit", (acc_total - dlv_total + BURST_LEN) <= int'(fifo_space), 1);
                burst_idx++;
                held_addr = avm_address;
            end

            if (bq.size() > 0 && (!rand_gap || $urandom_range(2) != 0)) begin
                avm_readdata = word_of(addr_at(bq[0], widx));
                avm_readdatavalid = 1'b1;
                widx++;
                if (widx == BURST_LEN) begin
                    void'(bq.pop_front());
                    widx = 0;
                end
                dlv_total++;
                last_drive_cyc = cyc;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = {$urandom, $urandom};
            end

            avm_waitrequest = rand_wait ? ($urandom_range(1) == 1) : 1'b0;
            if (avm_read && !avm_waitrequest) begin
                bq.push_back(avm_address);
                acc_total += BURST_LEN;
                req_pending = 1'b0;
            end else begin
                req_pending = avm_read;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic arm(input logic [ADDR_W-1:0] base);
        exp_base  = base;
        rx_idx    = 0;
        burst_idx = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_address"}, avm_address, 0);
        chk({tag, "_avm_burstcount"}, avm_burstcount, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_pix_sof"}, pix_sof, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_clear0"}, clear_buffer0, 0);
        chk({tag, "_clear1"}, clear_buffer1, 0);
    endtask

    // One frame: expected source buffer and base; repeat frames end on busy
    // falling instead of a clear pulse.
    task automatic run_frame(input int buf_i, input logic [ADDR_W-1:0] base,
                             input bit is_repeat, input bit drop_en);
        int c0;
        int c1;
        bit seen;
        arm(base);
        c0 = clr0_cnt;
        c1 = clr1_cnt;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            step();
            seen = busy;
        end
        chk("frame_start", seen, 1);
        if (drop_en) rd_enable = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 4000 && !seen; t++) begin
            step();
            seen = is_repeat ? !busy : ((clr0_cnt + clr1_cnt) != (c0 + c1));
        end
        chk("frame_end", seen, 1);
        chk("frame_words", rx_idx, FRAME_WORDS);
        chk("frame_bursts", burst_idx, NBURST);
        if (is_repeat) begin
            chk("repeat_no_clear0", clr0_cnt, c0);
            chk("repeat_no_clear1", clr1_cnt, c1);
        end else begin
            chk("clear0_count", clr0_cnt - c0, buf_i == 0);
            chk("clear1_count", clr1_cnt - c1, buf_i == 1);
            chk("clear_latency", clear_cyc - last_drive_cyc, 1);
            step();
            chk("busy_after_clear", busy, 0);
            chk("clear_width", (clr0_cnt + clr1_cnt) - (c0 + c1), 1);
        end
        $display("frame buf=%0d base=%07h repeat=%0d words=%0d bursts=%0d", buf_i, base, is_repeat, rx_idx, burst_idx);
    endtask

    initial begin
        int c1_before;
        bit seen;

        reset_n = 1'b0;
        rd_enable = 1'b0;
        buffer0_full = 1'b0;
        buffer1_full = 1'b0;
        buffer0_offset = '0;
        buffer1_offset = '0;
        fifo_space = 10'd64;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;

        repeat (3) step();
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        step();

        // Basic frame from buffer 0
        buffer0_offset = 26'h100;
        buffer0_full = 1'b1;
        rd_enable = 1'b1;
        run_frame(0, 26'h100, 1'b0, 1'b0);
        buffer0_full = 1'b0;

`ifdef DDR3_RD_FRAME_REPEAT_EN
        run_frame(0, 26'h100, 1'b1, 1'b1);
`else
        arm(26'h100);
        repeat (30) step();
        chk("idle_busy", busy, 0);
        chk("idle_no_request", burst_idx, 0);
        chk("idle_no_data", rx_idx, 0);
        $display("idle check busy=%0d bursts=%0d", busy, burst_idx);
`endif
        rd_enable = 1'b0;
        repeat (4) step();

        // Ping-pong: current buffer is 1 after the first frame
        buffer0_offset = 26'h000;
        buffer1_offset = 26'h400;
        buffer0_full = 1'b1;
        buffer1_full = 1'b1;
        rd_enable = 1'b1;
        run_frame(1, 26'h400, 1'b0, 1'b0);
        run_frame(0, 26'h000, 1'b0, 1'b0);
        run_frame(1, 26'h400, 1'b0, 1'b1);
        buffer0_full = 1'b0;
        buffer1_full = 1'b0;
        repeat (4) step();

        // Back-pressure and address wrap on buffer 0
        fifo_space = 10'd10;
        rand_wait = 1'b1;
        rand_gap = 1'b1;
        buffer0_offset = 26'h3FFFFF8;
        buffer0_full = 1'b1;
        rd_enable = 1'b1;
        run_frame(0, 26'h3FFFFF8, 1'b0, 1'b1);
        buffer0_full = 1'b0;
        rand_wait = 1'b0;
        rand_gap = 1'b0;
        fifo_space = 10'd64;
        repeat (4) step();

        // Reset in the middle of a buffer 1 frame
        buffer0_offset = 26'h600;
        buffer1_offset = 26'h200;
        buffer0_full = 1'b1;
        buffer1_full = 1'b1;
        arm(26'h200);
        c1_before = clr1_cnt;
        rd_enable = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            step();
            seen = (burst_idx >= 2);
        end
        chk("abort_two_bursts", seen, 1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        $display("reset asserted mid-frame after %0d bursts", burst_idx);
        repeat (3) step();
        reset_n = 1'b1;
        run_frame(0, 26'h600, 1'b0, 1'b1);
        chk("abort_no_clear1", clr1_cnt, c1_before);

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
